// File: rtl/exc_ctrl.sv
// Exception sequencer: picks the highest-priority cause in IDLE, drives cp0 entry/eret, flushes and redirects fetch.
// Latency: cause at T -> cp0_op at T+1 -> redirect at T+2; no backpressure, causes seen while busy are dropped.
module exc_ctrl #(
  parameter logic [29:0] HANDLER_ADDR = 30'h0000_0020,
  parameter int          ERR_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_ov,
  input  logic [29:0]      ex_pc,
  input  logic             id_ri,
  input  logic             id_syscall,
  input  logic             id_eret,
  input  logic [29:0]      id_pc,
  input  logic [5:0]       ext_int,
  input  logic             cp0_exl,
  input  logic             cp0_ie,
  input  logic [5:0]       cp0_im,
  input  logic [31:0]      cp0_epc_in,
  output logic [2:0]       cp0_op,
  output logic [29:0]      cp0_epc,
  output logic [4:0]       cp0_exccode,
  output logic             kill,
  output logic             flush,
  output logic             pc_redirect,
  output logic [29:0]      pc_target,
  output logic             busy,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTER   = 3'd1,
    S_REDIR   = 3'd2,
    S_HANDLER = 3'd3,
    S_ERET    = 3'd4,
    S_RET     = 3'd5
  } state_t;

  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_ENTRY = 3'b011;
  localparam logic [2:0] OP_ERET  = 3'b100;

  localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  state_t           r_state;
  state_t           w_next;
  logic [5:0]       r_int_sync;
  logic [4:0]       r_code;
  logic [29:0]      r_epc;
  logic [ERR_W-1:0] r_err;

  logic             w_sync;
  logic             w_int_req;
  logic             w_cause;
  logic             w_err_inc;
  logic [4:0]       w_sel_code;
  logic [29:0]      w_sel_epc;
  logic             w_unused;

  // The two byte-offset bits of EPC never reach the word-addressed fetch path.
  assign w_unused  = ^cp0_epc_in[1:0];

  assign w_sync    = ex_ov | id_ri | id_syscall;
  assign w_int_req = (|(r_int_sync & cp0_im)) & cp0_ie & ~cp0_exl;
  assign w_cause   = w_sync | w_int_req;

  always_comb begin
    w_sel_code = 5'd0;
    w_sel_epc  = id_pc;
    if (ex_ov) begin
      w_sel_code = 5'd12;
      w_sel_epc  = ex_pc;
    end else if (id_ri) begin
      w_sel_code = 5'd10;
    end else if (id_syscall) begin
      w_sel_code = 5'd8;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_int_sync <= 6'd0;
      r_code     <= 5'd0;
      r_epc      <= 30'd0;
      r_err      <= '0;
    end else begin
      r_state    <= w_next;
      r_int_sync <= ext_int;
      if (r_state == S_IDLE && w_cause) begin
        r_code <= w_sel_code;
        r_epc  <= w_sel_epc;
      end
      if (w_err_inc && r_err != ERR_MAX) begin
        r_err <= r_err + ERR_ONE;
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    w_err_inc = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cause) begin
          w_next = S_ENTER;
        end else if (id_eret) begin
          if (cp0_exl) w_next = S_ERET;
          else         w_err_inc = 1'b1;
        end
      end
      S_ENTER: w_next = S_REDIR;
      S_REDIR: w_next = S_HANDLER;
      S_HANDLER: begin
        // Nested synchronous faults are only counted; an eret in the same cycle still wins.
        if (w_sync)  w_err_inc = 1'b1;
        if (id_eret) w_next    = S_ERET;
      end
      S_ERET:  w_next = S_RET;
      S_RET:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    cp0_op      = OP_NONE;
    cp0_epc     = 30'd0;
    cp0_exccode = 5'd0;
    flush       = 1'b0;
    pc_redirect = 1'b0;
    pc_target   = 30'd0;
    busy        = 1'b0;
    case (r_state)
      S_ENTER: begin
        cp0_op      = OP_ENTRY;
        cp0_epc     = r_epc;
        cp0_exccode = r_code;
        flush       = 1'b1;
        busy        = 1'b1;
      end
      S_REDIR: begin
        pc_redirect = 1'b1;
        pc_target   = HANDLER_ADDR;
        flush       = 1'b1;
        busy        = 1'b1;
      end
      S_ERET: begin
        cp0_op = OP_ERET;
        flush  = 1'b1;
        busy   = 1'b1;
      end
      S_RET: begin
        pc_redirect = 1'b1;
        pc_target   = cp0_epc_in[31:2];
        flush       = 1'b1;
        busy        = 1'b1;
      end
      default: ;
    endcase
  end

  assign kill    = ~rst & (r_state == S_IDLE) & w_cause;
  assign err_cnt = r_err;

endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: directed scenarios plus a long randomized run against a queue-based reference model.
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_ov, id_ri, id_syscall, id_eret;
  logic [29:0] ex_pc, id_pc;
  logic [5:0]  ext_int, cp0_im;
  logic        cp0_exl, cp0_ie;
  logic [31:0] cp0_epc_in;
  logic [2:0]  cp0_op;
  logic [29:0] cp0_epc, pc_target;
  logic [4:0]  cp0_exccode;
  logic        kill, flush, pc_redirect, busy;
  logic [7:0]  err_cnt;

  int checks = 0;
  int errors = 0;

  exc_ctrl #(.HANDLER_ADDR(30'h20), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .ex_ov(ex_ov), .ex_pc(ex_pc), .id_ri(id_ri),
    .id_syscall(id_syscall), .id_eret(id_eret), .id_pc(id_pc), .ext_int(ext_int),
    .cp0_exl(cp0_exl), .cp0_ie(cp0_ie), .cp0_im(cp0_im), .cp0_epc_in(cp0_epc_in),
    .cp0_op(cp0_op), .cp0_epc(cp0_epc), .cp0_exccode(cp0_exccode), .kill(kill),
    .flush(flush), .pc_redirect(pc_redirect), .pc_target(pc_target), .busy(busy),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: every accepted event schedules its two busy cycles as queued output slots.
  typedef struct {
    logic [2:0]  op;
    logic [29:0] epc;
    logic [4:0]  code;
    logic        redir;
    logic        use_epc;
  } slot_t;

  slot_t      m_q[$];
  bit         m_inh;
  logic [5:0] m_intp;
  logic [7:0] m_err;

  logic [2:0]  e_op;
  logic [29:0] e_epc, e_target;
  logic [4:0]  e_code;
  logic        e_kill, e_flush, e_redir, e_busy;
  logic [7:0]  e_err;

  function automatic logic m_int_req();
    return (|(m_intp & cp0_im)) & cp0_ie & ~cp0_exl;
  endfunction

  task automatic idle_inputs();
    ex_ov = 0; id_ri = 0; id_syscall = 0; id_eret = 0;
    ex_pc = 30'h0; id_pc = 30'h0; ext_int = 6'h0; cp0_im = 6'h0;
    cp0_exl = 0; cp0_ie = 0; cp0_epc_in = 32'h0;
  endtask

  task automatic expect_now();
    #1;
    e_busy = (m_q.size() != 0);
    e_op = 3'b000; e_epc = '0; e_code = '0; e_flush = 0; e_redir = 0; e_target = '0;
    if (e_busy) begin
      e_op    = m_q[0].op;
      e_epc   = m_q[0].epc;
      e_code  = m_q[0].code;
      e_flush = 1'b1;
      e_redir = m_q[0].redir;
      if (m_q[0].redir) e_target = m_q[0].use_epc ? cp0_epc_in[31:2] : 30'h20;
    end
    e_kill = !rst && !e_busy && !m_inh && (ex_ov || id_ri || id_syscall || m_int_req());
    e_err  = m_err;
  endtask

  task automatic push_eret();
    m_q.push_back(slot_t'{3'b100, 30'h0, 5'h0, 1'b0, 1'b0});
    m_q.push_back(slot_t'{3'b000, 30'h0, 5'h0, 1'b1, 1'b1});
  endtask

  task automatic step();
    logic        sync;
    logic        ireq;
    logic [4:0]  code;
    logic [29:0] epc;
    sync = ex_ov | id_ri | id_syscall;
    ireq = m_int_req();
    if (rst) begin
      m_q.delete();
      m_inh = 0;
      m_err = 8'h0;
      m_intp = 6'h0;
    end else begin
      if (m_q.size() != 0) begin
        void'(m_q.pop_front());
      end else if (!m_inh) begin
        if (sync || ireq) begin
          if (ex_ov)           begin code = 5'd12; epc = ex_pc; end
          else if (id_ri)      begin code = 5'd10; epc = id_pc; end
          else if (id_syscall) begin code = 5'd8;  epc = id_pc; end
          else                 begin code = 5'd0;  epc = id_pc; end
          m_q.push_back(slot_t'{3'b011, epc, code, 1'b0, 1'b0});
          m_q.push_back(slot_t'{3'b000, 30'h0, 5'h0, 1'b1, 1'b0});
          m_inh = 1;
        end else if (id_eret) begin
          if (cp0_exl) push_eret();
          else if (m_err != 8'hFF) m_err = m_err + 8'd1;
        end
      end else begin
        if (sync && m_err != 8'hFF) m_err = m_err + 8'd1;
        if (id_eret) begin
          push_eret();
          m_inh = 0;
        end
      end
      m_intp = ext_int;
    end
    @(negedge clk);
  endtask

  task automatic leave_handler();
    idle_inputs();
    id_eret = 1; cp0_exl = 1;
    step();
    idle_inputs();
    step();
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    step();
    ex_ov = 1; id_syscall = 1; id_eret = 1; cp0_exl = 1;
    expect_now();
    checks++;
    if ({cp0_op, cp0_epc, cp0_exccode, kill, flush, pc_redirect, pc_target, busy, err_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: op=%h epc=%h code=%h kill=%b flush=%b redir=%b tgt=%h busy=%b err=%h, all required 0",
               cp0_op, cp0_epc, cp0_exccode, kill, flush, pc_redirect, pc_target, busy, err_cnt);
    end
    step();
    idle_inputs();
    rst = 0;
    step();
  endtask

  task automatic test_syscall_eret();
    id_syscall = 1; id_pc = 30'h40;
    expect_now();
    checks++;
    if (kill !== 1'b1 || cp0_op !== 3'b000) begin
      errors++; $display("FAIL syscall_kill: kill=%b op=%h, required kill=1 op=0", kill, cp0_op);
    end
    step();
    idle_inputs();
    expect_now();
    checks++;
    if (cp0_op !== 3'b011 || cp0_exccode !== 5'd8 || cp0_epc !== 30'h40 || flush !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL syscall_entry: op=%h code=%0d epc=%h flush=%b busy=%b, required 3 8 40 1 1",
                         cp0_op, cp0_exccode, cp0_epc, flush, busy);
    end
    step();
    expect_now();
    checks++;
    if (pc_redirect !== 1'b1 || pc_target !== 30'h20 || flush !== 1'b1 || cp0_op !== 3'b000) begin
      errors++; $display("FAIL syscall_redir: redir=%b tgt=%h flush=%b op=%h, required 1 20 1 0",
                         pc_redirect, pc_target, flush, cp0_op);
    end
    step();
    expect_now();
    checks++;
    if (busy !== 1'b0 || pc_redirect !== 1'b0 || flush !== 1'b0) begin
      errors++; $display("FAIL syscall_handler: busy=%b redir=%b flush=%b, required 0", busy, pc_redirect, flush);
    end
    id_eret = 1; cp0_exl = 1; cp0_epc_in = 32'h104;
    step();
    id_eret = 0;
    expect_now();
    checks++;
    if (cp0_op !== 3'b100 || flush !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL eret_op: op=%h flush=%b busy=%b, required 4 1 1", cp0_op, flush, busy);
    end
    step();
    expect_now();
    checks++;
    if (pc_redirect !== 1'b1 || pc_target !== 30'h41 || cp0_op !== 3'b000) begin
      errors++; $display("FAIL eret_redir: redir=%b tgt=%h op=%h, required 1 41 0", pc_redirect, pc_target, cp0_op);
    end
    step();
    idle_inputs();
    id_syscall = 1; id_pc = 30'h55;
    expect_now();
    checks++;
    if (busy !== 1'b0 || kill !== 1'b1) begin
      errors++; $display("FAIL eret_back_idle: busy=%b kill=%b, required 0 1", busy, kill);
    end
    step();
    idle_inputs();
    step();
    step();
    leave_handler();
  endtask

  task automatic test_priority();
    int entries;
    ex_ov = 1; ex_pc = 30'h11; id_syscall = 1; id_pc = 30'h12;
    step();
    idle_inputs();
    expect_now();
    checks++;
    if (cp0_op !== 3'b011 || cp0_exccode !== 5'd12 || cp0_epc !== 30'h11) begin
      errors++; $display("FAIL priority_sel: op=%h code=%0d epc=%h, required 3 12 11", cp0_op, cp0_exccode, cp0_epc);
    end
    entries = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      expect_now();
      if (cp0_op == 3'b011) entries++;
    end
    checks++;
    if (entries != 1) begin
      errors++; $display("FAIL priority_single: entries=%0d, required 1", entries);
    end
    leave_handler();
  endtask

  task automatic test_interrupt();
    ext_int = 6'b000001; cp0_im = 6'b000001; cp0_ie = 1; id_pc = 30'h77;
    expect_now();
    checks++;
    if (kill !== 1'b0) begin
      errors++; $display("FAIL int_sync_delay: kill=%b, required 0", kill);
    end
    step();
    expect_now();
    checks++;
    if (kill !== 1'b1) begin
      errors++; $display("FAIL int_kill: kill=%b, required 1", kill);
    end
    step();
    idle_inputs();
    expect_now();
    checks++;
    if (cp0_op !== 3'b011 || cp0_exccode !== 5'd0 || cp0_epc !== 30'h77) begin
      errors++; $display("FAIL int_entry: op=%h code=%0d epc=%h, required 3 0 77", cp0_op, cp0_exccode, cp0_epc);
    end
    step();
    step();
    leave_handler();
    ext_int = 6'b000001; cp0_im = 6'b000000; cp0_ie = 1;
    for (int i = 0; i < 4; i++) begin
      expect_now();
      checks++;
      if (kill !== 1'b0 || cp0_op !== 3'b000) begin
        errors++; $display("FAIL int_masked: cycle %0d kill=%b op=%h, required 0 0", i, kill, cp0_op);
      end
      step();
    end
    idle_inputs();
    step();
  endtask

  task automatic test_errors();
    id_syscall = 1; id_pc = 30'h30;
    step();
    idle_inputs();
    step();
    step();
    id_syscall = 1;
    expect_now();
    checks++;
    if (kill !== 1'b0) begin
      errors++; $display("FAIL nested_nokill: kill=%b, required 0", kill);
    end
    step();
    idle_inputs();
    expect_now();
    checks++;
    if (cp0_op !== 3'b000 || err_cnt !== 8'd1 || busy !== 1'b0) begin
      errors++; $display("FAIL nested_count: op=%h err=%0d busy=%b, required 0 1 0", cp0_op, err_cnt, busy);
    end
    ex_ov = 1; id_eret = 1; cp0_exl = 1;
    step();
    idle_inputs();
    expect_now();
    checks++;
    if (cp0_op !== 3'b100 || err_cnt !== 8'd2) begin
      errors++; $display("FAIL ov_with_eret: op=%h err=%0d, required 4 2", cp0_op, err_cnt);
    end
    step();
    step();
    id_eret = 1; cp0_exl = 0;
    step();
    idle_inputs();
    expect_now();
    checks++;
    if (cp0_op !== 3'b000 || err_cnt !== 8'd3 || busy !== 1'b0) begin
      errors++; $display("FAIL bad_eret: op=%h err=%0d busy=%b, required 0 3 0", cp0_op, err_cnt, busy);
    end
  endtask

  task automatic test_saturation();
    id_eret = 1; cp0_exl = 0;
    for (int i = 0; i < 300; i++) step();
    idle_inputs();
    expect_now();
    checks++;
    if (err_cnt !== 8'hFF) begin
      errors++; $display("FAIL err_saturate: err=%h, required ff", err_cnt);
    end
  endtask

  task automatic test_reset_mid();
    id_syscall = 1; id_pc = 30'h66;
    step();
    idle_inputs();
    rst = 1;
    expect_now();
    checks++;
    if (cp0_op !== 3'b011) begin
      errors++; $display("FAIL rstmid_enter: op=%h, required 3", cp0_op);
    end
    step();
    rst = 0;
    expect_now();
    checks++;
    if ({cp0_op, cp0_epc, cp0_exccode, kill, flush, pc_redirect, pc_target, busy, err_cnt} !== '0) begin
      errors++; $display("FAIL rstmid_clear: op=%h redir=%b flush=%b busy=%b err=%h, required all 0",
                         cp0_op, pc_redirect, flush, busy, err_cnt);
    end
    step();
    expect_now();
    checks++;
    if (pc_redirect !== 1'b0 || cp0_op !== 3'b000 || busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_noredir: redir=%b op=%h busy=%b, required 0", pc_redirect, cp0_op, busy);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      rst        = ($urandom_range(0, 249) == 0);
      ex_ov      = ($urandom_range(0, 11) == 0);
      id_ri      = ($urandom_range(0, 13) == 0);
      id_syscall = ($urandom_range(0, 11) == 0);
      id_eret    = ($urandom_range(0, 5) == 0);
      ex_pc      = 30'($urandom);
      id_pc      = 30'($urandom);
      ext_int    = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'h0;
      cp0_im     = 6'($urandom);
      cp0_ie     = 1'($urandom);
      cp0_exl    = ($urandom_range(0, 2) != 0);
      cp0_epc_in = $urandom;
      expect_now();
      checks++;
      if ({cp0_op, cp0_epc, cp0_exccode, kill, flush, pc_redirect, pc_target, busy, err_cnt} !==
          {e_op, e_epc, e_code, e_kill, e_flush, e_redir, e_target, e_busy, e_err}) begin
        errors++;
        $display("FAIL random cyc %0d: op=%h epc=%h code=%0d kill=%b flush=%b redir=%b tgt=%h busy=%b err=%h; required op=%h epc=%h code=%0d kill=%b flush=%b redir=%b tgt=%h busy=%b err=%h",
                 c, cp0_op, cp0_epc, cp0_exccode, kill, flush, pc_redirect, pc_target, busy, err_cnt,
                 e_op, e_epc, e_code, e_kill, e_flush, e_redir, e_target, e_busy, e_err);
      end
      step();
    end
  endtask

  initial begin
    m_inh = 0; m_intp = 6'h0; m_err = 8'h0;
    rst = 1;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_syscall_eret();
    test_priority();
    test_interrupt();
    test_errors();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Pipeline-side exception sequencer that drives the coprocessor-0 register file.
- Each cycle it collects exception causes from the ID and EX stages and external interrupt lines, and selects one by priority.
- It issues the cp0 exception-entry (3'b011) or eret (3'b100) operation with the EPC and ExcCode.
- It flushes the pipeline, redirects fetch to the handler or back to EPC, and counts illegal nested events.

Parameters:
- HANDLER_ADDR, 30'h0000_0020: word address of the exception handler (byte 0x80).
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- ex_ov  in  1  arithmetic overflow of the instruction in EX.
- ex_pc  in  30  word PC of the instruction in EX.
- id_ri  in  1  reserved instruction decoded in ID.
- id_syscall  in  1  syscall decoded in ID.
- id_eret  in  1  eret decoded in ID.
- id_pc  in  30  word PC of the instruction in ID.
- ext_int  in  6  external interrupt lines, level-sensitive, asynchronous to decode.
- cp0_exl  in  1  Status.EXL from cp0.
- cp0_ie  in  1  Status.IE from cp0.
- cp0_im  in  6  Status.IM[7:2] from cp0.
- cp0_epc_in  in  32  current EPC from cp0 (byte address).
- cp0_op  out  3  3'b000 none, 3'b011 exception entry, 3'b100 eret.
- cp0_epc  out  30  word PC to save in EPC.
- cp0_exccode  out  5  cause code.
- kill  out  1  combinational; squash writeback of the faulting instruction and all younger ones this cycle.
- flush  out  1  flush IF/ID/EX pipeline registers.
- pc_redirect  out  1  load pc_target into PC.
- pc_target  out  30  redirect word address.
- busy  out  1  sequencer not in IDLE or HANDLER.
- err_cnt  out  ERR_W  saturating count of ignored nested exceptions or illegal erets.

Behaviour:
- Reset: state=IDLE, int_sync=0, err_cnt=0.
  - All outputs 0: cp0_op=000, flush=0, pc_redirect=0, pc_target=0, cp0_epc=0, cp0_exccode=0, kill=0, busy=0.
  - Reset in any state, mid-sequence, aborts the sequence with no cp0_op issued afterwards.
- Interrupt sampling: int_sync<=ext_int every cycle (one register stage). int_req = |(int_sync & cp0_im) & cp0_ie & ~cp0_exl.
- Priority, high to low, evaluated in IDLE and HANDLER:
  - ex_ov: code 5'd12, epc=ex_pc.
  - id_ri: code 5'd10, epc=id_pc.
  - id_syscall: code 5'd8, epc=id_pc.
  - int_req: code 5'd0, epc=id_pc.
- Losing causes are dropped. The interrupt stays visible while its line is high.
- kill=1 combinationally in any cycle where IDLE selects a cause.
- States:
  - IDLE: on a selected cause, latch code/epc and go to ENTER. On id_eret with cp0_exl=1, go to ERET. On id_eret with cp0_exl=0, ignore it, err_cnt+1.
  - ENTER (1 cycle): cp0_op=011, cp0_epc/cp0_exccode = latched values, flush=1, busy=1. Go to REDIR.
  - REDIR (1 cycle): pc_redirect=1, pc_target=HANDLER_ADDR, flush=1, busy=1. Go to HANDLER.
  - HANDLER: normal execution inside the handler.
    - id_eret goes to ERET.
    - Any synchronous cause (ex_ov, id_ri, id_syscall) is ignored, err_cnt+1, no kill. EPC is never overwritten.
    - Interrupts are masked by cp0_exl.
    - ex_ov together with id_eret in the same cycle: error counted, eret still taken.
  - ERET (1 cycle): cp0_op=100, flush=1, busy=1. Go to RET.
  - RET (1 cycle): pc_redirect=1, pc_target=cp0_epc_in[31:2], flush=1, busy=1. Go to IDLE.
- err_cnt saturates at all-ones; it never wraps.
- Latency:
  - Cause sampled in cycle T → cp0_op=011 in T+1 → redirect in T+2 → handler fetch in T+3.
  - eret in ID at T → cp0_op=100 in T+1 → redirect to EPC in T+2.
- Causes arriving while busy=1 are ignored and not counted; flushed instructions cannot raise them.
- cp0_op is non-zero for exactly one cycle per accepted event.

Test Plan:
- Syscall: id_syscall=1, id_pc=30'h40, IDLE → kill=1 at T; at T+1 cp0_op=011, cp0_exccode=8, cp0_epc=30'h40, flush=1; at T+2 pc_redirect=1, pc_target=30'h20; at T+3 busy=0.
- Priority: ex_ov=1 (ex_pc=30'h11), id_syscall=1 (id_pc=30'h12) same cycle → cp0_exccode=12, cp0_epc=30'h11; exactly one entry sequence.
- Interrupt:
  - ext_int=6'b000001, cp0_im=6'b000001, cp0_ie=1, cp0_exl=0 → entry two cycles after the line rises, code 0, epc=id_pc.
  - Same stimulus with cp0_im=0 → no entry.
- Eret round trip: in HANDLER with cp0_exl=1, id_eret=1, cp0_epc_in=32'h104 → next cycle cp0_op=100; following cycle pc_redirect=1, pc_target=30'h41; then IDLE.
- Errors and saturation:
  - id_syscall in HANDLER → no cp0_op, err_cnt+1.
  - id_eret with cp0_exl=0 → err_cnt+1.
  - 300 such events → err_cnt=8'hFF.
- Reset mid-sequence: assert rst during ENTER → next cycle all outputs 0, state IDLE, no REDIR pulse, err_cnt=0.
